packet_route_table: RTL
=======================

PACKET_ROUTE_TABLE -- requirements
Module: packet_route_table

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 6, number of table entries (2..256).
REQ-002 SHALL have parameter DATA_W, default 24, width of each entry.
REQ-003 SHALL have parameter INIT_VALUE, default 0, value written to each entry by an init sweep.
REQ-004 SHALL derive localparam IDX_W = $clog2(NUM_ENTRIES).
REQ-005 SHALL have one clock and a synchronous, active-high reset.
- clock  in  1  rising-edge clock
- clear  in  1  reset
REQ-006 SHALL have the following command and response ports:
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when both are high
- cmd_op  in  2  operation code
- cmd_index  in  IDX_W+1  entry index (extra bit allows out-of-range detection)
- cmd_data  in  DATA_W  write value or addend
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed this cycle when both are high
- rsp_data  out  DATA_W  response value
- rsp_status  out  2  response status
- busy  out  1  init sweep in progress

Function
REQ-007 States SHALL be INIT, IDLE and RESP.
- INIT: writes INIT_VALUE to one entry per cycle, from index 0 up to NUM_ENTRIES-1.
- INIT -> IDLE after the last entry is written.
REQ-008 cmd_ready SHALL equal (state!=INIT) && (!rsp_valid || rsp_ready), so back-to-back commands are accepted at one per cycle.
REQ-009 Accepted commands SHALL behave per cmd_op as follows; every response SHALL be registered and appear with rsp_valid the cycle after acceptance.
- 00 READ: rsp_data = entry.
- 01 WRITE: entry <= cmd_data; rsp_data = old entry value.
- 10 ADD: entry <= entry + cmd_data; rsp_data = new entry value.
- 11 CLEAR_ALL: enter INIT; the response is issued the cycle after the sweep ends, with rsp_data=INIT_VALUE.
REQ-010 rsp_status codes SHALL be: 00 OK, 01 BAD_INDEX, 10 OVERFLOW.
REQ-011 A command with cmd_index >= NUM_ENTRIES (except CLEAR_ALL, which ignores the index) SHALL leave the table unchanged and respond with rsp_data=0, status 01.
REQ-012 rsp_valid, rsp_data and rsp_status SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 With state RESP and rsp_ready=1, a new accepted command SHALL keep the state in RESP; with no new command the state SHALL return to IDLE.
REQ-014 busy SHALL be 1 exactly while the state is INIT.
REQ-015 No command SHALL be accepted during INIT.
REQ-016 ADD SHALL compute with DATA_W+1 bits; a carry-out SHALL give status 10 (result handling per REQ-020).
REQ-017 Back-to-back commands to the same entry SHALL see the previous command's result (no stale read).

Reset
REQ-018 While clear=1, the block SHALL be held at these values:
- state=INIT, sweep index=0.
- rsp_valid=0, rsp_data=0, rsp_status=00.
- cmd_ready=0, busy=1.
REQ-019 After clear falls, the sweep SHALL take NUM_ENTRIES cycles, and cmd_ready SHALL rise in cycle NUM_ENTRIES.
- clear asserted mid-sweep or mid-response restarts the sweep and drops any pending response.

Configuration
REQ-020 Macro ROUTE_TABLE_SAT_EN SHALL select the ADD overflow result; status 10 on carry-out in both cases.
- Defined: ADD saturates to all-ones.
- Undefined: ADD wraps modulo 2^DATA_W.

Structure
REQ-021 Package route_table_pkg SHALL hold the following:
- op enum (OP_READ, OP_WRITE, OP_ADD, OP_CLEAR_ALL)
- status enum (ST_OK, ST_BAD_INDEX, ST_OVERFLOW)
- state enum (S_INIT, S_IDLE, S_RESP)
REQ-022 Sub-module route_table_alu SHALL implement the combinational add with carry and saturation; it is parametrised by DATA_W.

Verification
REQ-023 Reset, defaults, INIT_VALUE=5: release clear -> busy=1 for 6 cycles, then cmd_ready=1; READ idx 3 -> rsp_data=5, status 00.
REQ-024 WRITE idx 2 data 0x00ABCD, then READ idx 2 on the next cycle -> responses 5 (old value) then 0x00ABCD, with no bubble.
REQ-025 Entry 0=0xFFFFF0, ADD 0x20 -> status 10; rsp_data=0xFFFFFF with the macro, 0x000010 without.
REQ-026 READ idx 6 and idx 7 -> status 01, rsp_data=0, table unchanged.
REQ-027 Backpressure: rsp_ready=0 for 4 cycles -> response held stable, cmd_ready=0; rsp_ready=1 -> next command accepted in that cycle.
REQ-028 CLEAR_ALL, then clear pulsed at sweep cycle 3 -> sweep restarts, no response emitted, all entries read back INIT_VALUE.

Source files
------------

// File: rtl/route_table_pkg.sv
// Shared types for the packet route table: opcodes, response status codes and controller states.
package route_table_pkg;

   typedef enum logic [1:0] {
      OP_READ      = 2'b00,
      OP_WRITE     = 2'b01,
      OP_ADD       = 2'b10,
      OP_CLEAR_ALL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_BAD_INDEX = 2'b01,
      ST_OVERFLOW  = 2'b10
   } status_e;

   typedef enum logic [1:0] {
      S_INIT = 2'b00,
      S_IDLE = 2'b01,
      S_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/route_table_alu.sv
// Combinational entry adder with carry-out; overflow result selected by ROUTE_TABLE_SAT_EN
// (defined: saturate to all-ones, undefined: wrap modulo 2^DATA_W).
module route_table_alu
   import route_table_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              carry_o
);

   logic [DATA_W:0] wide;

   function automatic logic [DATA_W-1:0] fold_overflow(input logic [DATA_W:0] w);
`ifdef ROUTE_TABLE_SAT_EN
      return w[DATA_W] ? {DATA_W{1'b1}} : w[DATA_W-1:0];
`else
      return w[DATA_W-1:0];
`endif
   endfunction

   always_comb begin
      wide    = {1'b0, a_i} + {1'b0, b_i};
      carry_o = wide[DATA_W];
      sum_o   = fold_overflow(wide);
   end

endmodule

// File: rtl/packet_route_table.sv
// Indexed route table with read/write/add/clear-all commands, one registered response per command
// and a one-entry-per-cycle init sweep. Overflow behaviour of ADD follows ROUTE_TABLE_SAT_EN.
module packet_route_table
   import route_table_pkg::*;
#(
   parameter int                NUM_ENTRIES = 6,
   parameter int                DATA_W      = 24,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
   localparam int               IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W:0]    cmd_index,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status,
   output logic              busy
);

   localparam logic [IDX_W:0]   NUM_E    = (IDX_W+1)'(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  sweep_q, sweep_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_status_q, rsp_status_d;
   logic [DATA_W-1:0] mem_q [NUM_ENTRIES];

   logic              we;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              accept;
   logic              bad_idx;
   logic [IDX_W-1:0]  cmd_idx;
   logic [DATA_W-1:0] entry;
   logic [DATA_W-1:0] add_sum;
   logic              add_carry;
   op_e               op;

   // The response register is the RESP state itself; clear masks handshakes in its first cycle.
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;
   assign busy       = clear || (state_q == S_INIT);
   assign cmd_ready  = !clear && (state_q != S_INIT) && (!rsp_valid || rsp_ready);
   assign accept     = cmd_valid && cmd_ready;
   assign bad_idx    = (cmd_index >= NUM_E);
   assign cmd_idx    = cmd_index[IDX_W-1:0];
   assign entry      = bad_idx ? '0 : mem_q[cmd_idx];
   assign op         = op_e'(cmd_op);

   route_table_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i     (entry),
      .b_i     (cmd_data),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      pend_d       = pend_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      we           = 1'b0;
      wr_idx       = cmd_idx;
      wr_data      = cmd_data;
      case (state_q)
         S_INIT: begin
            we      = 1'b1;
            wr_idx  = sweep_q;
            wr_data = INIT_VALUE;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_IDX) begin
               sweep_d = '0;
               if (pend_q) begin
                  state_d      = S_RESP;
                  pend_d       = 1'b0;
                  rsp_data_d   = INIT_VALUE;
                  rsp_status_d = ST_OK;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            if (rsp_valid && rsp_ready) state_d = S_IDLE;
            if (accept) begin
               if (op == OP_CLEAR_ALL) begin
                  state_d = S_INIT;
                  sweep_d = '0;
                  pend_d  = 1'b1;
               end else begin
                  state_d      = S_RESP;
                  rsp_status_d = ST_OK;
                  if (bad_idx) begin
                     rsp_data_d   = '0;
                     rsp_status_d = ST_BAD_INDEX;
                  end else begin
                     case (op)
                        OP_READ:  rsp_data_d = entry;
                        OP_WRITE: begin
                           rsp_data_d = entry;
                           we         = 1'b1;
                        end
                        default: begin
                           rsp_data_d = add_sum;
                           we         = 1'b1;
                           wr_data    = add_sum;
                           if (add_carry) rsp_status_d = ST_OVERFLOW;
                        end
                     endcase
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q      <= S_INIT;
         sweep_q      <= '0;
         pend_q       <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         pend_q       <= pend_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   // Table storage carries no reset; the init sweep defines its contents.
   always_ff @(posedge clock) begin
      if (we) mem_q[wr_idx] <= wr_data;
   end

endmodule
